// File: rtl/sub_sched_pkg.sv
// Shared definitions for the round-robin subtract scheduler: default sizes and FSM states.
// The FIX state is only used when SUB_RR_ABS_DIFF_EN is defined.
package sub_sched_pkg;

  localparam int SUB_WIDTH = 10;
  localparam int SUB_NREQ  = 4;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_FIX = 1'b1
  } sub_state_e;

endpackage

// File: rtl/sub_rr_scheduler_if.sv
// Request/response bundle between the requesters/consumer (master) and the scheduler (slave).
interface sub_rr_scheduler_if
  import sub_sched_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH,
  parameter int NREQ  = SUB_NREQ
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_ready;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_diff;
  logic                  rsp_borrow;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_diff, rsp_borrow
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_diff, rsp_borrow
  );
endinterface

// File: rtl/sub_rr_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after i_ptr, wrapping at NREQ-1.
module rr_arbiter
  import sub_sched_pkg::*;
#(
  parameter int NREQ = SUB_NREQ,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  input  logic            i_en,
  output logic [NREQ-1:0] o_gnt,
  output logic [IDW-1:0]  o_idx,
  output logic            o_any
);

  logic [IDW-1:0] w_j;
  logic           w_found;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_j     = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_j = IDW'((int'(i_ptr) + k) % NREQ);
      if (i_en && !w_found && i_req[w_j]) begin
        o_gnt[w_j] = 1'b1;
        o_idx      = w_j;
        w_found    = 1'b1;
      end
    end
    o_any = w_found;
  end

endmodule

// File: rtl/sub_rr_scheduler.sv
// Shares one WIDTH-bit subtractor among NREQ requesters with round-robin grants and one result register.
// Optional SUB_RR_ABS_DIFF_EN: A<B results are re-subtracted (B-A) in a FIX cycle to give |A-B|.
module sub_rr_scheduler
  import sub_sched_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH,
  parameter int NREQ  = SUB_NREQ
) (
  input  logic               clk,
  input  logic               rst_n,
  sub_rr_scheduler_if.slave  bus
);

  localparam int IDW = $clog2(NREQ);

  logic             r_rsp_valid;
  logic [IDW-1:0]   r_rsp_id;
  logic [WIDTH-1:0] r_rsp_diff;
  logic             r_rsp_borrow;
  logic [IDW-1:0]   r_rr_ptr;

  logic             w_slot_free;
  logic             w_run;
  logic             w_en;
  logic [NREQ-1:0]  w_gnt;
  logic [IDW-1:0]   w_idx;
  logic             w_xfer;
  logic [WIDTH-1:0] w_sel_a;
  logic [WIDTH-1:0] w_sel_b;
  logic [WIDTH-1:0] w_op_a;
  logic [WIDTH-1:0] w_op_b;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_diff;
  logic             w_borrow;

  function automatic logic [IDW-1:0] next_ptr(input logic [IDW-1:0] idx);
    if (idx == IDW'(NREQ - 1)) return '0;
    return idx + 1'b1;
  endfunction

`ifdef SUB_RR_ABS_DIFF_EN
  sub_state_e       r_state;
  logic [WIDTH-1:0] r_fix_a;
  logic [WIDTH-1:0] r_fix_b;
  logic [IDW-1:0]   r_fix_id;

  assign w_run = (r_state == ST_RUN);
`else
  assign w_run = 1'b1;
`endif

  // Grant only when the result slot can take a new value this cycle.
  assign w_slot_free = ~r_rsp_valid | bus.rsp_ready;
  assign w_en        = rst_n & w_slot_free & w_run;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .i_req (bus.req_valid),
    .i_ptr (r_rr_ptr),
    .i_en  (w_en),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_xfer)
  );

  assign bus.req_ready = w_gnt;

  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) begin
        w_sel_a = bus.req_a[i*WIDTH +: WIDTH];
        w_sel_b = bus.req_b[i*WIDTH +: WIDTH];
      end
    end
  end

`ifdef SUB_RR_ABS_DIFF_EN
  // In FIX the latched operands are fed back swapped so the same unit yields B-A.
  assign w_op_a = w_run ? w_sel_a : r_fix_b;
  assign w_op_b = w_run ? w_sel_b : r_fix_a;
`else
  assign w_op_a = w_sel_a;
  assign w_op_b = w_sel_b;
`endif

  assign w_sum    = {1'b0, w_op_a} + {1'b0, ~w_op_b} + (WIDTH+1)'(1);
  assign w_diff   = w_sum[WIDTH-1:0];
  assign w_borrow = ~w_sum[WIDTH];

`ifdef SUB_RR_ABS_DIFF_EN
  always_ff @(posedge clk) begin
    if (w_xfer) begin
      r_fix_a  <= w_sel_a;
      r_fix_b  <= w_sel_b;
      r_fix_id <= w_idx;
    end
  end
`endif

  // Result stage: load on transfer, hold under backpressure, clear when drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= '0;
      r_rsp_diff   <= '0;
      r_rsp_borrow <= 1'b0;
      r_rr_ptr     <= '0;
`ifdef SUB_RR_ABS_DIFF_EN
      r_state      <= ST_RUN;
`endif
    end else begin
`ifdef SUB_RR_ABS_DIFF_EN
      if (r_state == ST_FIX) begin
        r_rsp_valid  <= 1'b1;
        r_rsp_id     <= r_fix_id;
        r_rsp_diff   <= w_diff;
        r_rsp_borrow <= 1'b1;
        r_state      <= ST_RUN;
      end else
`endif
      if (w_xfer) begin
        r_rr_ptr <= next_ptr(w_idx);
`ifdef SUB_RR_ABS_DIFF_EN
        if (w_borrow) begin
          r_rsp_valid <= 1'b0;
          r_state     <= ST_FIX;
        end else
`endif
        begin
          r_rsp_valid  <= 1'b1;
          r_rsp_id     <= w_idx;
          r_rsp_diff   <= w_diff;
          r_rsp_borrow <= w_borrow;
        end
      end else if (w_slot_free) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_id     = r_rsp_id;
  assign bus.rsp_diff   = r_rsp_diff;
  assign bus.rsp_borrow = r_rsp_borrow;

endmodule
